// File: rtl/cpu_trace_emitter.sv
// Serialises one register-write or memory-write record per request into an
// ASCII trace stream, one character per cycle, with back-to-back frames.
module cpu_trace_emitter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [13:0] req_time,
  input  logic [31:0] req_pc,
  input  logic        req_is_reg,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic [7:0]  char,
  output logic        char_valid
);

  typedef enum logic [1:0] {IDLE, EMIT, LAST} state_e;

  state_e      state_q, state_d;
  logic [5:0]  pos_q, pos_d;
  logic [15:0] tbcd_q, tbcd_d;
  logic [2:0]  tlen_q, tlen_d;
  logic [31:0] pc_q, pc_d;
  logic        is_reg_q, is_reg_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  rbcd_q, rbcd_d;
  logic [1:0]  rlen_q, rlen_d;
  logic [31:0] data_q, data_d;

  logic        accept;
  logic [13:0] t_sat;
  logic [5:0]  s_pc, s_c, s_f, flen, s_ar, s_d, s_end;
  logic [7:0]  ch;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'b0, n} : 8'h57 + {4'b0, n};
  endfunction

  // i is the digit position counted from the most significant nibble
  function automatic logic [3:0] nib8(input logic [31:0] w, input logic [2:0] i);
    return w[{~i, 2'b00} +: 4];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      tbcd_q   <= '0;
      tlen_q   <= '0;
      pc_q     <= '0;
      is_reg_q <= 1'b0;
      addr_q   <= '0;
      rbcd_q   <= '0;
      rlen_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      tbcd_q   <= tbcd_d;
      tlen_q   <= tlen_d;
      pc_q     <= pc_d;
      is_reg_q <= is_reg_d;
      addr_q   <= addr_d;
      rbcd_q   <= rbcd_d;
      rlen_q   <= rlen_d;
      data_q   <= data_d;
    end
  end

  // Field start offsets within the frame; T and R have variable length
  always_comb begin
    s_pc  = 6'd2 + {3'b0, tlen_q};
    s_c   = s_pc + 6'd8;
    s_f   = s_c + 6'd3;
    flen  = is_reg_q ? {4'b0, rlen_q} : 6'd8;
    s_ar  = s_f + flen;
    s_d   = s_ar + 6'd4;
    s_end = s_d + 6'd8;
  end

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    tbcd_d   = tbcd_q;
    tlen_d   = tlen_q;
    pc_d     = pc_q;
    is_reg_d = is_reg_q;
    addr_d   = addr_q;
    rbcd_d   = rbcd_q;
    rlen_d   = rlen_q;
    data_d   = data_q;
    t_sat    = (req_time > 14'd9999) ? 14'd9999 : req_time;
    case (state_q)
      IDLE: if (accept) state_d = EMIT;
      EMIT: begin
        pos_d = pos_q + 6'd1;
        if (pos_q == s_end - 6'd1) state_d = LAST;
      end
      LAST: state_d = accept ? EMIT : IDLE;
      default: state_d = IDLE;
    endcase
    // Decimal digits are resolved at capture so emission never stalls
    if (accept) begin
      pos_d    = '0;
      tbcd_d   = {4'(t_sat / 14'd1000), 4'((t_sat / 14'd100) % 14'd10),
                  4'((t_sat / 14'd10) % 14'd10), 4'(t_sat % 14'd10)};
      tlen_d   = (t_sat >= 14'd1000) ? 3'd4 : (t_sat >= 14'd100) ? 3'd3 :
                 (t_sat >= 14'd10) ? 3'd2 : 3'd1;
      pc_d     = req_pc;
      is_reg_d = req_is_reg;
      addr_d   = req_addr;
      rbcd_d   = {4'(req_addr[4:0] / 5'd10), 4'(req_addr[4:0] % 5'd10)};
      rlen_d   = (req_addr[4:0] >= 5'd10) ? 2'd2 : 2'd1;
      data_d   = req_data;
    end
  end

  always_comb begin
    ch = 8'h00;
    if (pos_q == 6'd0)                  ch = "^";
    else if (pos_q <= {3'b0, tlen_q})   ch = 8'h30 + {4'b0, tbcd_q[{~(pos_q[1:0] + 2'd3 - tlen_q[1:0]), 2'b00} +: 4]};
    else if (pos_q < s_pc)              ch = "@";
    else if (pos_q < s_c)               ch = hex_char(nib8(pc_q, pos_q[2:0] - s_pc[2:0]));
    else if (pos_q == s_c)              ch = ":";
    else if (pos_q == s_c + 6'd1)       ch = " ";
    else if (pos_q < s_f)               ch = is_reg_q ? "$" : "*";
    else if (pos_q < s_ar) begin
      if (is_reg_q) ch = 8'h30 + {4'b0, rbcd_q[{~(pos_q[0] ^ s_f[0] ^ rlen_q[0]), 2'b00} +: 4]};
      else          ch = hex_char(nib8(addr_q, pos_q[2:0] - s_f[2:0]));
    end
    else if (pos_q < s_d) begin
      case (pos_q[1:0] - s_ar[1:0])
        2'd1:    ch = "<";
        2'd2:    ch = "=";
        default: ch = " ";
      endcase
    end
    else if (pos_q < s_end)             ch = hex_char(nib8(data_q, pos_q[2:0] - s_d[2:0]));
    else                                ch = "#";
  end

  always_comb begin
    char_valid = (state_q != IDLE);
    char       = char_valid ? ch : 8'h00;
    req_ready  = (state_q != EMIT);
  end

endmodule
